// File: rtl/theta_pkg.sv
// Shared constants, FSM state type and small helpers for the theta update datapath.
package theta_pkg;
    localparam int W     = 64;
    localparam int NLANE = 25;
    localparam int NCOL  = 5;

    typedef enum logic [2:0] {IDLE, LOAD_PAR, CALC_D, APPLY, DONE} state_t;

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
        return {v[W-2:0], v[W-1]};
    endfunction

    function automatic logic [2:0] inc5(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction
endpackage

// File: rtl/theta_apply_if.sv
// Sequencer handshake plus parity/state-lane memory ports of the theta update block.
interface theta_apply_if;
    import theta_pkg::*;

    logic         start;
    logic         ready;
    logic         busy;
    logic [2:0]   par_addr;
    logic [W-1:0] par_data;
    logic [4:0]   lane_rd_addr;
    logic [W-1:0] lane_rd_data;
    logic         lane_wr_en;
    logic [4:0]   lane_wr_addr;
    logic [W-1:0] lane_wr_data;
    logic         par_err;

    modport master (
        output start, par_data, lane_rd_data,
        input  ready, busy, par_addr, lane_rd_addr, lane_wr_en, lane_wr_addr, lane_wr_data, par_err
    );

    modport slave (
        input  start, par_data, lane_rd_data,
        output ready, busy, par_addr, lane_rd_addr, lane_wr_en, lane_wr_addr, lane_wr_data, par_err
    );
endinterface

// File: rtl/theta_d_gen.sv
// Combinational D generation: D[x] = C[x-1] ^ rotl1(C[x+1]), indices mod 5.
module theta_d_gen
    import theta_pkg::*;
(
    input  logic [W-1:0] c [NCOL],
    output logic [W-1:0] d [NCOL]
);
    for (genvar x = 0; x < NCOL; x++) begin : g_col
        assign d[x] = c[(x + 4) % NCOL] ^ rotl1(c[(x + 1) % NCOL]);
    end
endmodule

// File: rtl/theta_apply.sv
// Theta update: load 5 parity lanes, form D, then XOR D[x] into all 25 state lanes.
// Optional recomputed-parity check enabled by defining THETA_PARCHK_EN.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD_PAR | read parity lanes 0..4 into C regs (6 cycles)
// CALC_D   | register D[0..4]
// APPLY    | pipelined read/modify/write of lanes 0..24 (26 cycles)
// DONE     | ready pulse, then back to IDLE
module theta_apply
    import theta_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    theta_apply_if.slave bus
);
    state_t       state, state_nxt;
    logic [2:0]   ld_cnt;
    logic [4:0]   ap_cnt;
    logic [2:0]   x_cnt;
    logic [W-1:0] c_reg  [NCOL];
    logic [W-1:0] d_reg  [NCOL];
    logic [W-1:0] d_comb [NCOL];
    logic         wr_phase;

    theta_d_gen u_d_gen (.c(c_reg), .d(d_comb));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start) state_nxt = LOAD_PAR;
            LOAD_PAR: if (ld_cnt == 3'd5) state_nxt = CALC_D;
            CALC_D:   state_nxt = APPLY;
            APPLY:    if (ap_cnt == 5'(NLANE)) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Write lags read by one cycle; x_cnt follows the write address mod 5.
    assign wr_phase         = (state == APPLY) && (ap_cnt != 5'd0);
    assign bus.busy         = (state != IDLE);
    assign bus.ready        = (state == DONE);
    assign bus.par_addr     = (state == LOAD_PAR && ld_cnt < 3'd5) ? ld_cnt : 3'd0;
    assign bus.lane_rd_addr = (state == APPLY && ap_cnt < 5'(NLANE)) ? ap_cnt : 5'd0;
    assign bus.lane_wr_en   = wr_phase;
    assign bus.lane_wr_addr = wr_phase ? ap_cnt - 5'd1 : 5'd0;
    assign bus.lane_wr_data = wr_phase ? (bus.lane_rd_data ^ d_reg[x_cnt]) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            ap_cnt <= '0;
            x_cnt  <= '0;
            for (int i = 0; i < NCOL; i++) begin
                c_reg[i] <= '0;
                d_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    ld_cnt <= '0;
                    ap_cnt <= '0;
                    x_cnt  <= '0;
                end
                LOAD_PAR: begin
                    ld_cnt <= ld_cnt + 3'd1;
                    if (ld_cnt != 3'd0) c_reg[ld_cnt - 3'd1] <= bus.par_data;
                end
                CALC_D: begin
                    for (int i = 0; i < NCOL; i++) d_reg[i] <= d_comb[i];
                end
                APPLY: begin
                    ap_cnt <= ap_cnt + 5'd1;
                    if (wr_phase) x_cnt <= inc5(x_cnt);
                end
                default: ;
            endcase
        end
    end

`ifdef THETA_PARCHK_EN
    logic [W-1:0] acc [NCOL];
    logic         err_q;
    logic         mism;

    always_comb begin
        mism = 1'b0;
        for (int i = 0; i < NCOL; i++) if (acc[i] != c_reg[i]) mism = 1'b1;
    end

    // Accumulates pre-update lanes so the DONE compare sees the parity the C regs claimed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int i = 0; i < NCOL; i++) acc[i] <= '0;
        end else if (state == IDLE && bus.start) begin
            err_q <= 1'b0;
            for (int i = 0; i < NCOL; i++) acc[i] <= '0;
        end else if (wr_phase) begin
            acc[x_cnt] <= acc[x_cnt] ^ bus.lane_rd_data;
        end else if (state == DONE && mism) begin
            err_q <= 1'b1;
        end
    end

    assign bus.par_err = err_q | ((state == DONE) && mism);
`else
    assign bus.par_err = 1'b0;
`endif
endmodule

// File: tb/tb_theta_apply.sv
// Self-checking bench for theta_apply: memory models, write log and a spec-level reference model.
module tb_theta_apply;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    theta_apply_if bus();
    theta_apply dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef THETA_PARCHK_EN
    localparam bit PARCHK = 1'b1;
`else
    localparam bit PARCHK = 1'b0;
`endif
    localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

    logic [63:0] par_mem  [5];
    logic [63:0] lane_mem [25];
    logic [63:0] exp_d    [5];
    bit          exp_mism;
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  wlog_addr [$];
    logic [63:0] wlog_data [$];

    always @(posedge clk) begin
        bus.par_data     <= (bus.par_addr < 3'd5) ? par_mem[bus.par_addr] : 64'd0;
        bus.lane_rd_data <= (bus.lane_rd_addr < 5'd25) ? lane_mem[bus.lane_rd_addr] : 64'd0;
    end

    always @(negedge clk) begin
        if (bus.lane_wr_en === 1'b1) begin
            wlog_addr.push_back(bus.lane_wr_addr);
            wlog_data.push_back(bus.lane_wr_data);
        end
    end

    function automatic logic [63:0] rl(input logic [63:0] v);
        return (v << 1) | (v >> 63);
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic build_model();
        logic [63:0] p;
        exp_mism = 1'b0;
        for (int x = 0; x < 5; x++) begin
            exp_d[x] = par_mem[(x + 4) % 5] ^ rl(par_mem[(x + 1) % 5]);
            p = 64'd0;
            for (int y = 0; y < 5; y++) p = p ^ lane_mem[x + 5 * y];
            if (p != par_mem[x]) exp_mism = 1'b1;
        end
    endtask

    task automatic fill(input bit rand_lanes, input bit rand_par);
        for (int i = 0; i < 25; i++) lane_mem[i] = rand_lanes ? r64() : 64'd0;
        for (int i = 0; i < 5; i++)  par_mem[i]  = rand_par ? r64() : 64'd0;
    endtask

    task automatic make_par_consistent();
        for (int x = 0; x < 5; x++) begin
            par_mem[x] = 64'd0;
            for (int y = 0; y < 5; y++) par_mem[x] = par_mem[x] ^ lane_mem[x + 5 * y];
        end
    endtask

    // One full operation; restart_at pulses start during that cycle, hold keeps start high into a second run.
    task automatic run_and_check(input string name, input int restart_at, input bit hold);
        int   ready_n [$];
        int   window;
        int   exp_n;
        int   i;
        logic exp_busy;
        logic exp_err;
        build_model();
        wlog_addr.delete();
        wlog_data.delete();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        window = hold ? 75 : 40;
        for (int n = 1; n <= window; n++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) ready_n.push_back(n);
            exp_busy = hold ? (n <= 34 || (n >= 36 && n <= 69)) : (n <= 34);
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy cycle %0d got %b exp %b", name, n, bus.busy, exp_busy);
            end
            if (!hold) begin
                exp_err = PARCHK && exp_mism && (n >= 34);
                checks++;
                if (bus.par_err !== exp_err) begin
                    errors++;
                    $display("FAIL %s par_err cycle %0d got %b exp %b", name, n, bus.par_err, exp_err);
                end
            end
            if (hold) begin
                if (n == 36) bus.start = 1'b0;
            end else begin
                bus.start = (n == restart_at);
            end
        end
        bus.start = 1'b0;
        checks++;
        if (ready_n.size() != (hold ? 2 : 1)) begin
            errors++;
            $display("FAIL %s ready_count got %0d exp %0d", name, ready_n.size(), hold ? 2 : 1);
        end else begin
            checks++;
            if (ready_n[0] != 34) begin
                errors++;
                $display("FAIL %s ready_cycle got %0d exp 34", name, ready_n[0]);
            end
            if (hold) begin
                checks++;
                if (ready_n[1] != 69) begin
                    errors++;
                    $display("FAIL %s ready2_cycle got %0d exp 69", name, ready_n[1]);
                end
            end
        end
        exp_n = hold ? 50 : 25;
        checks++;
        if (wlog_addr.size() != exp_n) begin
            errors++;
            $display("FAIL %s write_count got %0d exp %0d", name, wlog_addr.size(), exp_n);
        end
        for (int k = 0; k < exp_n && k < wlog_addr.size(); k++) begin
            i = k % 25;
            checks++;
            if (wlog_addr[k] !== 5'(i)) begin
                errors++;
                $display("FAIL %s wr_addr[%0d] got %0d exp %0d", name, k, wlog_addr[k], i);
            end
            checks++;
            if (wlog_data[k] !== (lane_mem[i] ^ exp_d[i % 5])) begin
                errors++;
                $display("FAIL %s wr_data[%0d] got %h exp %h", name, k, wlog_data[k], lane_mem[i] ^ exp_d[i % 5]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.ready !== 1'b0)        begin errors++; $display("FAIL reset ready got %b exp 0", bus.ready); end
        if (bus.busy !== 1'b0)         begin errors++; $display("FAIL reset busy got %b exp 0", bus.busy); end
        if (bus.lane_wr_en !== 1'b0)   begin errors++; $display("FAIL reset wr_en got %b exp 0", bus.lane_wr_en); end
        if (bus.par_err !== 1'b0)      begin errors++; $display("FAIL reset par_err got %b exp 0", bus.par_err); end
        if (bus.par_addr !== 3'd0)     begin errors++; $display("FAIL reset par_addr got %0d exp 0", bus.par_addr); end
        if (bus.lane_rd_addr !== 5'd0) begin errors++; $display("FAIL reset rd_addr got %0d exp 0", bus.lane_rd_addr); end
        if (bus.lane_wr_addr !== 5'd0) begin errors++; $display("FAIL reset wr_addr got %0d exp 0", bus.lane_wr_addr); end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero();
        fill(1'b0, 1'b0);
        run_and_check("zero", 0, 1'b0);
    endtask

    task automatic test_c1();
        logic [63:0] e;
        fill(1'b0, 1'b0);
        par_mem[1] = 64'h1;
        run_and_check("c1", 0, 1'b0);
        for (int k = 0; k < 25 && k < wlog_data.size(); k++) begin
            e = (k % 5 == 0) ? 64'h2 : (k % 5 == 2) ? 64'h1 : 64'h0;
            checks++;
            if (wlog_data[k] !== e) begin
                errors++;
                $display("FAIL c1_const lane %0d got %h exp %h", k, wlog_data[k], e);
            end
        end
    endtask

    task automatic test_c4msb();
        fill(1'b0, 1'b0);
        for (int i = 0; i < 25; i++) lane_mem[i] = 64'(i);
        par_mem[4] = MSB;
        run_and_check("c4msb", 0, 1'b0);
        if (wlog_data.size() >= 9) begin
            checks += 3;
            if (wlog_data[3] !== 64'h2)       begin errors++; $display("FAIL c4msb lane3 got %h exp 2", wlog_data[3]); end
            if (wlog_data[5] !== (MSB | 64'h5)) begin errors++; $display("FAIL c4msb lane5 got %h exp %h", wlog_data[5], MSB | 64'h5); end
            if (wlog_data[8] !== 64'h9)       begin errors++; $display("FAIL c4msb lane8 got %h exp 9", wlog_data[8]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            fill(1'b1, 1'b1);
            if (it == 1) make_par_consistent();
            run_and_check($sformatf("rand%0d", it), 0, 1'b0);
        end
    endtask

    task automatic test_restart_in_apply();
        fill(1'b1, 1'b1);
        run_and_check("restart", 20, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill(1'b1, 1'b1);
        run_and_check("b2b", 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit found;
        int rdy;
        fill(1'b1, 1'b1);
        wlog_addr.delete();
        wlog_data.delete();
        found = 1'b0;
        rdy = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.lane_wr_en === 1'b1 && bus.lane_wr_addr === 5'd10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid lane10_write got none exp write within 40 cycles");
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (bus.lane_wr_en !== 1'b0) begin errors++; $display("FAIL rst_mid wr_en got %b exp 0", bus.lane_wr_en); end
        if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rst_mid busy got %b exp 0", bus.busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) rdy++;
        end
        checks += 2;
        if (rdy != 0) begin errors++; $display("FAIL rst_mid ready_pulses got %0d exp 0", rdy); end
        if (wlog_addr.size() != 11) begin errors++; $display("FAIL rst_mid writes got %0d exp 11", wlog_addr.size()); end
        run_and_check("after_rst", 0, 1'b0);
    endtask

    task automatic test_parity();
        logic exp_err;
        fill(1'b0, 1'b0);
        par_mem[2] = 64'h1;
        run_and_check("par_bad", 0, 1'b0);
        @(negedge clk);
        exp_err = PARCHK;
        checks++;
        if (bus.par_err !== exp_err) begin
            errors++;
            $display("FAIL par_sticky got %b exp %b", bus.par_err, exp_err);
        end
        par_mem[2] = 64'h0;
        run_and_check("par_good", 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 25; i++) lane_mem[i] = 64'd0;
        for (int i = 0; i < 5; i++)  par_mem[i]  = 64'd0;
        test_reset();
        test_zero();
        test_c1();
        test_c4msb();
        test_random();
        test_restart_in_apply();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/theta_apply.md
Name: theta_apply

Overview:
- Consumer of the column-parity result in the encoder permutation datapath.
- Reads the 5 column-parity lanes C[0..4] and computes D[x] = C[(x+4)%5] ^ rotl(C[(x+1)%5], 1).
- XORs D[x] into all 25 state lanes A[x][y] in place. Lane index i = x + 5*y.
- Sits after the column-parity block. Driven by the top-level sequencer with a start/ready handshake.

Parameters:
- W, 64, lane width in bits.
- NLANE, 25, number of state lanes.
- NCOL, 5, number of columns / parity lanes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- ready  out  1  one-cycle pulse when the update is complete.
- busy  out  1  high from start acceptance until the ready cycle, inclusive.
- par_addr  out  3  parity-lane read address, 0..4.
- par_data  in  W  parity lane; synchronous, valid 1 cycle after par_addr.
- lane_rd_addr  out  5  state-lane read address, 0..24.
- lane_rd_data  in  W  state lane; synchronous, valid 1 cycle after lane_rd_addr.
- lane_wr_en  out  1  state-lane write strobe.
- lane_wr_addr  out  5  state-lane write address.
- lane_wr_data  out  W  updated lane, A ^ D[x].
- par_err  out  1  sticky parity mismatch flag (optional feature).

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE.
  - ready, busy, lane_wr_en, par_err = 0.
  - Addresses = 0; counters and D registers = 0.
- States: IDLE -> LOAD_PAR -> CALC_D -> APPLY -> DONE -> IDLE.
- IDLE:
  - start=1 at a clock edge moves to LOAD_PAR and asserts busy.
  - start in any other state is ignored, including DONE.
- LOAD_PAR, 6 cycles:
  - c5 counter drives par_addr 0..4 on cycles 1..5.
  - par_data is captured into C regs on cycles 2..6.
  - Exit after the capture of C[4].
- CALC_D, 1 cycle:
  - All five D[x] are registered from the formula above.
  - rotl by 1: bit j of the result = bit (j-1) mod W of the source.
- APPLY, 26 cycles, pipelined:
  - c25 counter issues lane_rd_addr 0..24 on cycles 1..25.
  - On cycles 2..26: lane_wr_en=1, lane_wr_addr = previous read address, lane_wr_data = lane_rd_data ^ D[addr mod 5].
  - The x index is tracked by a separate mod-5 counter; there is no divider.
  - Write addresses wrap 24 -> done. No address 25 is ever issued.
- DONE, 1 cycle: ready=1, busy=1, lane_wr_en=0. Next cycle goes to IDLE with busy=0.
- Latency: ready is high in the 34th cycle after the edge that accepted start (6+1+26+1).
- Write ordering:
  - Each lane is written exactly once, in ascending address order.
  - A read of lane i+1 and a write of lane i occur in the same cycle. The memory must tolerate this; addresses always differ.
- Reset mid-operation:
  - Immediate return to IDLE; lane_wr_en drops asynchronously.
  - Lanes already written stay modified; no rollback.
  - The next start performs a full run.
- start held high across DONE -> IDLE: a new run begins on the first IDLE edge.

Optional Feature:
- Macro THETA_PARCHK_EN.
- When defined:
  - During APPLY, each pre-update lane_rd_data is XOR-accumulated into a 5xW recomputed-parity register indexed by x. This register is cleared on start acceptance.
  - In DONE, it is compared with the C regs. On mismatch, par_err is set; it is sticky until rst or the next start acceptance.
- When undefined: no accumulator logic; par_err is tied to 0.

Decomposition:
- Package theta_pkg holds:
  - Constants W, NLANE, NCOL.
  - The state enum (IDLE, LOAD_PAR, CALC_D, APPLY, DONE).
  - Function rotl1, and mod-5 increment helper inc5.
- Sub-module theta_d_gen: purely combinational, C[0..4] in, D[0..4] out. Instantiated once; the output is registered in CALC_D.

Test Plan:
- All-zero state and parity, start pulse:
  - 25 writes of 0x0 to addresses 0..24.
  - ready pulses exactly at cycle 34; busy falls the cycle after.
- C[1]=0x1, others 0, state all zero:
  - Lanes 0,5,10,15,20 are written 0x2.
  - Lanes 2,7,12,17,22 are written 0x1.
  - All other lanes are written 0x0.
- C[4]=0x8000000000000000, state lane i = i:
  - D[0] = 0x8000000000000000 and D[3] = 0x1.
  - Lane 3 -> 0x2, lane 5 -> 0x8000000000000005, lane 8 -> 0x9.
- start re-asserted during APPLY: no restart, write sequence unchanged, single ready at cycle 34.
- rst asserted in APPLY after the lane-10 write:
  - lane_wr_en=0 immediately; ready never pulses.
  - A subsequent start completes a full 25-write run.
- With THETA_PARCHK_EN, C[2] deliberately corrupted to 0x1 on a zero state:
  - par_err=1 from the DONE cycle onward.
  - par_err is cleared on the next start acceptance.
  - A consistent run leaves par_err=0.
